// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decodes an RV32I instruction into ALU control and operands,
// and holds the result in a two-entry skid buffer so in_ready comes straight from a register.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] src_a,
    output logic [XLEN-1:0] src_b,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic [2:0]      funct3,
    output logic            is_branch,
    output logic            illegal
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]      aluCtl;
        logic [XLEN-1:0] srcA;
        logic [XLEN-1:0] srcB;
        logic [4:0]      rd;
        logic            regWrite;
        logic [2:0]      funct3;
        logic            isBranch;
        logic            illegal;
    } entry_t;

    // SUB and SRA are encoded as ADD and SRL with bit 0 set, so funct7=ALT only flips that bit.
    function automatic logic [3:0] baseCtl(input logic [2:0] f);
        case (f)
            3'b000:  baseCtl = ALU_ADD;
            3'b001:  baseCtl = ALU_SLL;
            3'b010:  baseCtl = ALU_SLT;
            3'b011:  baseCtl = ALU_SLTU;
            3'b100:  baseCtl = ALU_XOR;
            3'b101:  baseCtl = ALU_SRL;
            3'b110:  baseCtl = ALU_OR;
            default: baseCtl = ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        isShift;
    logic [31:0] immI;
    logic [31:0] immS;
    logic        ill;
    logic        wr;
    entry_t      dec;

    assign opcode  = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign isShift = (f3[1:0] == 2'b01);
    assign immI    = {{20{instr[31]}}, instr[31:20]};
    assign immS    = {{20{instr[31]}}, instr[31:25], instr[11:7]};

    always_comb begin
        dec        = '0;
        dec.rd     = instr[11:7];
        dec.funct3 = f3;
        dec.aluCtl = ALU_PASS;
        ill        = 1'b0;
        wr         = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.srcA   = rs1_data;
                dec.srcB   = rs2_data;
                dec.aluCtl = baseCtl(f3);
                wr         = 1'b1;
                if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) dec.aluCtl[0] = 1'b1;
                else if (f7 != F7_ZERO) ill = 1'b1;
                if (isShift) dec.srcB = {27'b0, rs2_data[4:0]};
            end
            OPC_OPIMM: begin
                dec.srcA   = rs1_data;
                dec.srcB   = immI;
                dec.aluCtl = baseCtl(f3);
                wr         = 1'b1;
                if (isShift) begin
                    dec.srcB = {27'b0, instr[24:20]};
                    if (f3 == 3'b101 && f7 == F7_ALT) dec.aluCtl[0] = 1'b1;
                    else if (f7 != F7_ZERO) ill = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.srcB = {instr[31:12], 12'b0};
                wr       = 1'b1;
            end
            OPC_AUIPC: begin
                dec.aluCtl = ALU_ADD;
                dec.srcA   = pc;
                dec.srcB   = {instr[31:12], 12'b0};
                wr         = 1'b1;
            end
            OPC_LOAD: begin
                dec.aluCtl = ALU_ADD;
                dec.srcA   = rs1_data;
                dec.srcB   = immI;
                wr         = 1'b1;
            end
            OPC_STORE: begin
                dec.aluCtl = ALU_ADD;
                dec.srcA   = rs1_data;
                dec.srcB   = immS;
            end
            OPC_BRANCH: begin
                dec.srcA     = rs1_data;
                dec.srcB     = rs2_data;
                dec.isBranch = 1'b1;
                case (f3[2:1])
                    2'b00:   dec.aluCtl = ALU_SUB;
                    2'b10:   dec.aluCtl = ALU_SLT;
                    2'b11:   dec.aluCtl = ALU_SLTU;
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec.aluCtl   = ALU_PASS;
            dec.srcA     = '0;
            dec.srcB     = '0;
            dec.isBranch = 1'b0;
            wr           = 1'b0;
        end
        dec.illegal  = ill;
        dec.regWrite = wr && (instr[11:7] != 5'd0);
    end

    logic   mValid_q, mValid_d;
    logic   sValid_q, sValid_d;
    entry_t mData_q, mData_d;
    entry_t sData_q, sData_d;
    logic   accept;
    logic   mFire;

    assign in_ready = !sValid_q;
    assign accept   = in_valid && in_ready;
    assign mFire    = mValid_q && out_ready;

    // M empty or draining: refill from S first, otherwise take the new entry; a stalled M parks it in S.
    always_comb begin
        mValid_d = mValid_q;
        mData_d  = mData_q;
        sValid_d = sValid_q;
        sData_d  = sData_q;
        if (flush) begin
            mValid_d = 1'b0;
            sValid_d = 1'b0;
        end else if (!mValid_q || mFire) begin
            if (sValid_q) begin
                mValid_d = 1'b1;
                mData_d  = sData_q;
                sValid_d = 1'b0;
            end else if (accept) begin
                mValid_d = 1'b1;
                mData_d  = dec;
            end else begin
                mValid_d = 1'b0;
            end
        end else if (accept) begin
            sValid_d = 1'b1;
            sData_d  = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mValid_q <= 1'b0;
            sValid_q <= 1'b0;
            mData_q  <= '0;
            sData_q  <= '0;
        end else begin
            mValid_q <= mValid_d;
            sValid_q <= sValid_d;
            mData_q  <= mData_d;
            sData_q  <= sData_d;
        end
    end

    assign out_valid   = mValid_q;
    assign alu_control = mData_q.aluCtl;
    assign src_a       = mData_q.srcA;
    assign src_b       = mData_q.srcB;
    assign rd          = mData_q.rd;
    assign reg_write   = mData_q.regWrite;
    assign funct3      = mData_q.funct3;
    assign is_branch   = mData_q.isBranch;
    assign illegal     = mData_q.illegal;

endmodule
